// File: rtl/csr_trap_ctrl_if.sv
// Bus bundle between the WB stage, the CSR file and IF as seen by the trap
// controller. The slave view belongs to the controller, the master view to
// whatever drives it (pipeline glue or a bench).
interface csr_trap_ctrl_if;
  logic        wb_valid;
  logic [31:0] wb_pc_in;
  logic [4:0]  wb_exc;
  logic        wb_ertn;
  logic        int_pending;
  logic [31:0] ex_entry;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        ertn_flush;
  logic        wb_commit;
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport slave (
    input  wb_valid, wb_pc_in, wb_exc, wb_ertn, int_pending, ex_entry, redirect_ready,
    output wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush, wb_commit,
           pipe_flush, redirect_valid, redirect_pc
  );

  modport master (
    output wb_valid, wb_pc_in, wb_exc, wb_ertn, int_pending, ex_entry, redirect_ready,
    input  wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush, wb_commit,
           pipe_flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Writeback-stage trap controller: picks one prioritised trap per WB
// instruction, pulses the CSR strobes, flushes the pipe and hands the CSR
// target PC to fetch over a valid/ready redirect.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | normal retirement, watching WB for a trap
// S_TRAP  | one-cycle wb_ex or ertn_flush strobe, CSR drives ex_entry
// S_FLUSH | pipe held flushed for FLUSH_CYCLES cycles
// S_REDIR | redirect offered to fetch until redirect_ready
module csr_trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  csr_trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_FLUSH, S_REDIR} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_wb_ex;
  logic        r_ertn_flush;
  logic        r_pipe_flush;
  logic        r_redirect_valid;
  logic [5:0]  r_ecode;
  logic [31:0] r_pc;
  logic [31:0] r_redirect_pc;

  logic        w_idle;
  logic        w_exc_any;
  logic        w_trap;
  logic [5:0]  w_ecode;

  assign w_idle    = (r_state == S_IDLE);
  assign w_exc_any = bus.int_pending | (|bus.wb_exc);
  assign w_trap    = bus.wb_valid & (w_exc_any | bus.wb_ertn);

  // Priority encode the exception code: interrupt, then ADEF, INE, SYS, BRK, ALE.
  always_comb begin
    w_ecode = 6'h00;
    if (bus.int_pending)    w_ecode = 6'h00;
    else if (bus.wb_exc[4]) w_ecode = 6'h08;
    else if (bus.wb_exc[3]) w_ecode = 6'h0D;
    else if (bus.wb_exc[2]) w_ecode = 6'h0B;
    else if (bus.wb_exc[1]) w_ecode = 6'h0C;
    else if (bus.wb_exc[0]) w_ecode = 6'h09;
  end

  // Trap sequencer with registered strobes, flush and redirect outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= 4'd0;
      r_wb_ex          <= 1'b0;
      r_ertn_flush     <= 1'b0;
      r_pipe_flush     <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_ecode          <= 6'h00;
      r_pc             <= 32'h0;
      r_redirect_pc    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trap) begin
            // ERTN only reaches here when no exception or interrupt is present.
            r_ecode      <= w_exc_any ? w_ecode : 6'h00;
            r_pc         <= bus.wb_pc_in;
            r_wb_ex      <= w_exc_any;
            r_ertn_flush <= ~w_exc_any;
            r_pipe_flush <= 1'b1;
            r_state      <= S_TRAP;
          end
        end
        S_TRAP: begin
          // CSR has selected eentry/era from the strobe during this cycle.
          r_wb_ex       <= 1'b0;
          r_ertn_flush  <= 1'b0;
          r_redirect_pc <= bus.ex_entry;
          r_cnt         <= CNT_LOAD;
          r_state       <= S_FLUSH;
        end
        S_FLUSH: begin
          if (r_cnt == 4'd0) begin
            r_redirect_valid <= 1'b1;
            r_state          <= S_REDIR;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_REDIR: begin
          if (bus.redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_pipe_flush     <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wb_commit      = bus.wb_valid & w_idle & ~w_trap;
  assign bus.wb_ex          = r_wb_ex;
  assign bus.ertn_flush     = r_ertn_flush;
  assign bus.wb_ecode       = r_ecode;
  assign bus.wb_esubcode    = 9'd0;
  assign bus.wb_pc          = r_pc;
  assign bus.pipe_flush     = r_pipe_flush;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: scenario tasks drive WB/CSR/IF stimulus and
// compare against expectations derived from the trap timeline.
module tb_csr_trap_ctrl;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  csr_trap_ctrl_if bus ();

  csr_trap_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Exception codes indexed by wb_exc bit position (bit0 = ALE ... bit4 = ADEF).
  function automatic logic [5:0] ref_ecode(input logic [4:0] exc, input bit intp);
    logic [5:0] codes [5];
    codes[0] = 6'h09; codes[1] = 6'h0C; codes[2] = 6'h0B; codes[3] = 6'h0D; codes[4] = 6'h08;
    if (intp) return 6'h00;
    for (int i = 4; i >= 0; i--) if (exc[i]) return codes[i];
    return 6'h00;
  endfunction

  function automatic logic [4:0] ctrl_vec();
    return {bus.wb_ex, bus.ertn_flush, bus.pipe_flush, bus.redirect_valid, bus.wb_commit};
  endfunction

  task automatic drive_idle_inputs();
    bus.wb_valid = 1'b0; bus.wb_pc_in = 32'h0; bus.wb_exc = 5'b0; bus.wb_ertn = 1'b0;
    bus.int_pending = 1'b0; bus.ex_entry = 32'h0; bus.redirect_ready = 1'b0;
  endtask

  // One whole trap: detect cycle, TRAP, FLUSH window, REDIR with 'stall' cycles of ready=0.
  // Inputs outside the detect cycle are random junk that the controller must ignore.
  task automatic run_trap(input string name, input logic [4:0] exc, input bit intp, input bit ertn,
                          input logic [31:0] pc, input logic [31:0] entry, input int stall);
    bit is_exc = intp || (exc != 5'b0);
    logic [5:0] exp_code = ref_ecode(exc, intp);
    int redir_k = 2 + FC;
    int total = redir_k + stall + 1;
    logic [4:0] exp_ctrl;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.wb_valid = 1'b1; bus.wb_pc_in = pc; bus.wb_exc = exc;
        bus.wb_ertn = ertn; bus.int_pending = intp;
      end else begin
        bus.wb_valid = 1'($urandom); bus.wb_pc_in = $urandom; bus.wb_exc = 5'($urandom);
        bus.wb_ertn = 1'($urandom); bus.int_pending = 1'($urandom);
      end
      bus.ex_entry = (k == 1) ? entry : $urandom;
      bus.redirect_ready = (k >= redir_k) ? (k == redir_k + stall) : 1'($urandom);
      #1;
      if (k == 0)             exp_ctrl = 5'b00000;
      else if (k == 1)        exp_ctrl = {is_exc, !is_exc, 1'b1, 1'b0, 1'b0};
      else if (k < redir_k)   exp_ctrl = 5'b00100;
      else                    exp_ctrl = 5'b00110;
      n_tests++;
      if (ctrl_vec() !== exp_ctrl) begin
        n_fail++;
        $display("FAIL %s ctrl k=%0d got={ex,ertn,flush,rv,commit}=%b exp=%b", name, k, ctrl_vec(), exp_ctrl);
      end
      if (k >= 1) begin
        n_tests++;
        if (bus.wb_pc !== pc) begin
          n_fail++;
          $display("FAIL %s wb_pc k=%0d got=%h exp=%h", name, k, bus.wb_pc, pc);
        end
        if (is_exc) begin
          n_tests++;
          if (bus.wb_ecode !== exp_code) begin
            n_fail++;
            $display("FAIL %s wb_ecode k=%0d got=%h exp=%h", name, k, bus.wb_ecode, exp_code);
          end
        end
      end
      if (k == 1) begin
        n_tests++;
        if (bus.wb_esubcode !== 9'd0) begin
          n_fail++;
          $display("FAIL %s wb_esubcode got=%h exp=0", name, bus.wb_esubcode);
        end
      end
      if (k >= redir_k) begin
        n_tests++;
        if (bus.redirect_pc !== entry) begin
          n_fail++;
          $display("FAIL %s redirect_pc k=%0d got=%h exp=%h", name, k, bus.redirect_pc, entry);
        end
      end
    end
  endtask

  // Idle cycles with a clean instruction: commit each cycle, nothing else active.
  task automatic run_commits(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_idle_inputs();
      bus.wb_valid = 1'b1; bus.wb_pc_in = $urandom; bus.ex_entry = $urandom;
      bus.redirect_ready = 1'($urandom);
      #1;
      n_tests++;
      if (ctrl_vec() !== 5'b00001) begin
        n_fail++;
        $display("FAIL %s commit i=%0d got={ex,ertn,flush,rv,commit}=%b exp=00001", name, i, ctrl_vec());
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if ({ctrl_vec(), bus.wb_ecode, bus.wb_esubcode, bus.wb_pc, bus.redirect_pc} !== '0) begin
      n_fail++;
      $display("FAIL %s zero-state got ctrl=%b ecode=%h sub=%h pc=%h rpc=%h exp=all 0",
               name, ctrl_vec(), bus.wb_ecode, bus.wb_esubcode, bus.wb_pc, bus.redirect_pc);
    end
  endtask

  task automatic test_reset();
    drive_idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset");
  endtask

  task automatic test_normal();
    run_commits("normal", 10);
  endtask

  task automatic test_sys();
    run_trap("sys", 5'b00100, 1'b0, 1'b0, 32'h1C000100, 32'h1C008000, 0);
    run_commits("sys_after", 1);
  endtask

  task automatic test_priority();
    run_trap("prio_int", 5'b00001, 1'b1, 1'b1, 32'h1C000040, 32'h1C00F000, 0);
    run_trap("prio_adef", 5'b11000, 1'b0, 1'b0, 32'h1C000044, 32'h1C00F000, 0);
    for (int i = 0; i < 12; i++) begin
      logic [4:0] exc = 5'($urandom);
      bit intp = ($urandom_range(0, 3) == 0);
      bit ertn = 1'($urandom);
      if (exc == 5'b0 && !intp && !ertn) exc = 5'b00010;
      run_trap("prio_rand", exc, intp, ertn, $urandom, $urandom, $urandom_range(0, 2));
      run_commits("prio_gap", $urandom_range(0, 2));
    end
  endtask

  task automatic test_ertn();
    run_trap("ertn", 5'b00000, 1'b0, 1'b1, 32'h1C000300, 32'h1C000204, 0);
    run_commits("ertn_after", 1);
  endtask

  task automatic test_stall();
    run_trap("stall", 5'b00010, 1'b0, 1'b0, 32'h1C000500, 32'h1C008800, 5);
    run_commits("stall_after", 2);
  endtask

  task automatic test_back_to_back();
    run_trap("b2b_0", 5'b00001, 1'b0, 1'b0, 32'h1C000600, 32'h1C009000, 0);
    run_trap("b2b_1", 5'b00000, 1'b0, 1'b1, 32'h1C000604, 32'h1C00A000, 0);
    run_trap("b2b_2", 5'b01000, 1'b1, 1'b0, 32'h1C000608, 32'h1C00B000, 0);
    run_commits("b2b_after", 1);
  endtask

  task automatic test_reset_mid_redir();
    for (int k = 0; k < 4 + FC; k++) begin
      @(negedge clk);
      drive_idle_inputs();
      if (k == 0) begin
        bus.wb_valid = 1'b1; bus.wb_exc = 5'b00100; bus.wb_pc_in = 32'h1C000700;
      end
      if (k == 1) bus.ex_entry = 32'h1C00C000;
    end
    #1;
    n_tests++;
    if (bus.redirect_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_redir pre-reset redirect_valid got=%b exp=1", bus.redirect_valid);
    end
    @(negedge clk);
    drive_idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("rst_redir");
    bus.wb_valid = 1'b1;
    #1;
    n_tests++;
    if (bus.wb_commit !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_redir commit got=%b exp=1", bus.wb_commit);
    end
    run_commits("rst_redir_after", 2);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_sys();
    test_priority();
    test_ertn();
    test_stall();
    test_back_to_back();
    test_reset_mid_redir();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
Writeback-stage trap controller that sequences the CSR file's exception and ERTN side effects. It arbitrates per-instruction exception flags and the pending interrupt into one prioritised trap, then pulses the CSR update strobes. It flushes the pipeline for a fixed window and then hands the CSR-supplied target PC to fetch through a valid/ready redirect handshake. It sits between the WB stage, the CSR module (wb_ex/ertn_flush/ex_entry) and IF.

Parameters:
FLUSH_CYCLES, 2, cycles pipe_flush is held in FLUSH before redirect is offered (legal range 1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wb_valid  in  1  WB holds a valid instruction this cycle
wb_pc_in  in  32  PC of the WB instruction
wb_exc  in  5  exception flags {ADEF, INE, SYS, BRK, ALE}, bit4..bit0
wb_ertn  in  1  WB instruction is ERTN
int_pending  in  1  enabled interrupt pending (already qualified by CRMD.IE)
ex_entry  in  32  CSR trap/return target (eentry when wb_ex, else era)
wb_ex  out  1  one-cycle exception strobe to CSR
wb_ecode  out  6  exception code to CSR
wb_esubcode  out  9  exception subcode to CSR
wb_pc  out  32  faulting PC to CSR (ERA source)
ertn_flush  out  1  one-cycle ERTN strobe to CSR
wb_commit  out  1  WB instruction retires normally (gates regfile/CSR writes)
pipe_flush  out  1  kill all younger stages
redirect_valid  out  1  fetch redirect offered
redirect_pc  out  32  fetch redirect target
redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset: state IDLE, counter 0. wb_ex, ertn_flush, wb_commit, pipe_flush and redirect_valid are 0. wb_ecode, wb_esubcode, wb_pc and redirect_pc are 0.
- Trap detect (IDLE only): trap = wb_valid & (int_pending | |wb_exc | wb_ertn).
- Priority and codes (wb_esubcode always 0):
  - INT: 0x00
  - ADEF: 0x08
  - INE: 0x0D
  - SYS: 0x0B
  - BRK: 0x0C
  - ALE: 0x09
  - ERTN is lowest; any exception or interrupt suppresses it, and ertn_flush is not pulsed.
- wb_commit = wb_valid & IDLE & ~trap. This is combinational. ERTN never commits; its effect is ertn_flush only.
- States: IDLE, TRAP, FLUSH, REDIR.
- IDLE: when trap=1 at the clock edge, register the winning ecode, wb_pc_in and an is_ertn flag, then go to TRAP.
- TRAP (exactly 1 cycle):
  - Exception case: wb_ex=1 with the registered ecode/pc.
  - ERTN case: ertn_flush=1.
  - pipe_flush=1.
  - Capture ex_entry into redirect_pc at the cycle end (CSR selects eentry/era combinationally from the strobes).
  - Load counter with FLUSH_CYCLES-1, then go to FLUSH.
- FLUSH: pipe_flush=1 and the counter decrements. When counter==0 at the edge, go to REDIR.
- REDIR:
  - pipe_flush=1, redirect_valid=1, redirect_pc stable.
  - Stay until redirect_ready=1; on that edge go to IDLE. The redirect is dropped the next cycle.
  - redirect_ready while not in REDIR is ignored.
- wb_ex and ertn_flush are high only in TRAP, and never both. wb_ecode/wb_pc hold their registered values outside TRAP.
- While not IDLE, wb_valid and all trap inputs are ignored; no commit and no new trap. A trap is accepted again in the first IDLE cycle.
- Reset in any state: next cycle IDLE with all reset values, an in-flight redirect is abandoned, and no strobe is emitted.
- Back-to-back: minimum trap-to-trap spacing is 1 + FLUSH_CYCLES + 1 cycles (redirect_ready tied high).

Test Plan:
- SYS: wb_valid=1, wb_exc=5'b00100, wb_pc_in=0x1C000100, ex_entry=0x1C008000 -> wb_ex pulses 1 cycle with ecode 0x0B and wb_pc=0x1C000100. pipe_flush is high 4 cycles. redirect_pc=0x1C008000 with redirect_valid on cycle 4 after detect. wb_commit=0.
- Priority: int_pending=1 with wb_exc=5'b00001 (ALE) and wb_ertn=1 -> ecode 0x00, no ertn_flush. Separately, wb_exc=5'b11000 -> ecode 0x08.
- ERTN: wb_ertn=1, ex_entry=0x1C000204 -> ertn_flush pulses 1 cycle, wb_ex=0, redirect_pc=0x1C000204, wb_commit=0.
- Redirect stall: redirect_ready=0 for 5 cycles then 1 -> redirect_valid and pipe_flush stay high with redirect_pc stable. IDLE is entered the cycle after ready. wb_valid+exc presented during the stall is not taken.
- Reset mid-REDIR: assert reset with redirect_valid=1 -> next cycle all outputs 0 and state IDLE. A subsequent wb_valid=1 with no flags gives wb_commit=1.
- Normal flow: wb_valid=1, no flags, int_pending=0 for 10 cycles -> wb_commit=1 each cycle, no strobes, pipe_flush=0.
